// File: rtl/timer_device_pkg.sv
// Shared constants for the memory-mapped timer: register word offsets,
// CTRL bit positions, MODE encodings and the FSM state encoding.
package timer_device_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 2;
  localparam int CTRL_W = 4;

  // Register word offsets (CPU address bits [3:2])
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_PRESET = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_COUNT  = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_RSVD   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // MODE encodings; 1x behaves as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Timer FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // Only the exact 01 encoding reloads; every other MODE value is one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return (mode == MODE_RELOAD);
  endfunction

endpackage

// File: rtl/timer_device.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a
// maskable level interrupt. Registers: CTRL (EN, MODE, IM), PRESET, COUNT.
module timer_device
  import timer_device_pkg::*;
#(
  parameter logic [DATA_W-1:0] PRESET_RESET = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              writeEnable,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData,
  output logic              irq
);

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   preset_q, preset_d;
  logic [DATA_W-1:0]   count_q, count_d;
  logic                flag_q, flag_d;

  logic                en;
  logic                im;
  logic [1:0]          mode;
  logic                wr_ctrl;
  logic                wr_preset;
  logic                flag_ack;
  logic                fsm_clr_en;
  logic                fsm_set_flag;
  logic                fsm_clr_flag;

  assign en   = ctrl_q[CTRL_EN_BIT];
  assign im   = ctrl_q[CTRL_IM_BIT];
  assign mode = ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB];

  // Decode CPU stores. A CTRL write acknowledges a pending flag unless it is
  // a pure unmask (IM=1 with EN=0), which lets software reveal an event that
  // expired while masked; any PRESET write also acknowledges.
  always_comb begin
    wr_ctrl   = writeEnable && (address == ADDR_CTRL);
    wr_preset = writeEnable && (address == ADDR_PRESET);
    flag_ack  = wr_preset ||
                (wr_ctrl && !(writeData[CTRL_IM_BIT] && !writeData[CTRL_EN_BIT]));
  end

  // Next-state and COUNT update for the IDLE/LOAD/CNT/INT sequence.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    fsm_clr_en   = 1'b0;
    fsm_set_flag = 1'b0;
    fsm_clr_flag = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q == '0) begin
          state_d      = ST_INT;
          fsm_set_flag = 1'b1;
        end else begin
          count_d = count_q - DATA_W'(1);
        end
      end
      ST_INT: begin
        if (is_reload(mode)) begin
          state_d      = ST_LOAD;
          fsm_clr_flag = 1'b1;
        end else begin
          state_d    = ST_IDLE;
          fsm_clr_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register file and flag next values; a CPU CTRL write overrides the FSM
  // clearing EN, and an expiry on the same edge as an acknowledge wins.
  always_comb begin
    ctrl_d = ctrl_q;
    if (fsm_clr_en) ctrl_d[CTRL_EN_BIT] = 1'b0;
    if (wr_ctrl)    ctrl_d = writeData[CTRL_W-1:0];

    preset_d = wr_preset ? writeData : preset_q;

    flag_d = flag_q;
    if (flag_ack || fsm_clr_flag) flag_d = 1'b0;
    if (fsm_set_flag)             flag_d = 1'b1;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      preset_q <= PRESET_RESET;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  // Combinational load data selected by the word address.
  always_comb begin
    readData = '0;
    unique case (address)
      ADDR_CTRL:   readData = {{(DATA_W-CTRL_W){1'b0}}, ctrl_q};
      ADDR_PRESET: readData = preset_q;
      ADDR_COUNT:  readData = count_q;
      ADDR_RSVD:   readData = '0;
      default:     readData = '0;
    endcase
  end

  assign irq = flag_q & im;

endmodule

// File: tb/tb_timer_device.sv
// Self-checking bench for timer_device: directed scenarios with literal
// expectations plus randomized bus traffic compared every cycle against a
// behavioural model of the timer.
module tb_timer_device;

  localparam logic [31:0] PR = 32'hA5A5_0003;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        writeEnable = 1'b0;
  logic [31:0] writeData = 32'd0;
  logic [31:0] readData;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  timer_device #(.PRESET_RESET(PR)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .writeEnable(writeEnable),
    .writeData  (writeData),
    .readData   (readData),
    .irq        (irq)
  );

  always #10 clk = ~clk;

  // Behavioural model. phase: 0 waiting for EN, 1 loads PRESET on the next
  // edge, 2 counting down, 3 just expired.
  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    bit          flag;
    int          phase;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(input mstate_t s, input logic we,
                                         input logic [1:0] a, input logic [31:0] d);
    mstate_t n;
    bit expire;
    bit en;
    bit reload;
    n      = s;
    expire = 1'b0;
    en     = s.ctrl[0];
    reload = (s.ctrl[2:1] == 2'b01);
    if (s.phase == 0) begin
      if (en) n.phase = 1;
    end else if (s.phase == 1) begin
      n.count = s.preset;
      n.phase = 2;
    end else if (s.phase == 2) begin
      if (!en) n.phase = 0;
      else if (s.count == 0) begin
        n.phase = 3;
        expire  = 1'b1;
      end else n.count = s.count - 1;
    end else begin
      if (reload) begin
        n.phase = 1;
        n.flag  = 1'b0;
      end else begin
        n.phase   = 0;
        n.ctrl[0] = 1'b0;
      end
    end
    if (we && a == 2'd0) begin
      n.ctrl = d[3:0];
      if (!(d[3] && !d[0])) n.flag = 1'b0;
    end
    if (we && a == 2'd1) begin
      n.preset = d;
      n.flag   = 1'b0;
    end
    if (expire) n.flag = 1'b1;
    return n;
  endfunction

  function automatic logic [31:0] model_read(input mstate_t s, input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, s.ctrl};
      2'd1:    return s.preset;
      2'd2:    return s.count;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m <= '{ctrl: 4'd0, preset: PR, count: 32'd0, flag: 1'b0, phase: 0};
    end else begin
      m <= model_next(m, writeEnable, address, writeData);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_rd", readData, model_read(m, address));
      check("model_irq", {31'd0, irq}, {31'd0, m.flag & m.ctrl[3]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address     = a;
    writeData   = d;
    writeEnable = 1'b1;
    tick();
    writeEnable = 1'b0;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, readData, exp);
  endtask

  task automatic chk_irq(input string name, input logic exp);
    #1;
    check(name, {31'd0, irq}, {31'd0, exp});
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;

    // Reset values of every register
    rd("rst_ctrl", 2'd0, 32'd0);
    rd("rst_preset", 2'd1, PR);
    rd("rst_count", 2'd2, 32'd0);
    rd("rst_rsvd", 2'd3, 32'd0);
    chk_irq("rst_irq", 1'b0);

    // One-shot, PRESET=3: COUNT 3,2,1,0 after e2..e5, irq after e6
    wr(2'd2, 32'h1234);                 // COUNT write is ignored
    rd("count_wr_ignored", 2'd2, 32'd0);
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);                    // e0
    tick(); tick();
    rd("os_count_e2", 2'd2, 32'd3);
    tick(); rd("os_count_e3", 2'd2, 32'd2);
    tick(); rd("os_count_e4", 2'd2, 32'd1);
    tick(); rd("os_count_e5", 2'd2, 32'd0); chk_irq("os_irq_e5", 1'b0);
    tick(); chk_irq("os_irq_e6", 1'b1);
    tick(); rd("os_en_cleared", 2'd0, 32'h8); chk_irq("os_irq_e7", 1'b1);
    tick(); tick(); tick();
    chk_irq("os_irq_held", 1'b1);
    wr(2'd0, 32'h0);
    chk_irq("os_irq_acked", 1'b0);

    // Auto-reload, PRESET=2: single-cycle pulses every 5 cycles
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);                    // e0
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk_irq($sformatf("ar_irq_e%0d", i), (i == 5 || i == 10));
    end
    rd("ar_en_kept", 2'd0, 32'hB);

    // PRESET=0: irq after e3
    do_reset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    tick(); tick(); chk_irq("p0_irq_e2", 1'b0);
    tick(); chk_irq("p0_irq_e3", 1'b1);

    // Same with IM=0, then unmask with EN=0
    do_reset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h1);
    tick(); tick(); tick(); chk_irq("mask_irq_e3", 1'b0);
    tick(); tick(); tick();
    rd("mask_ctrl", 2'd0, 32'h0);
    chk_irq("mask_irq_late", 1'b0);
    wr(2'd0, 32'h8);
    chk_irq("unmask_irq", 1'b1);

    // Mid-count PRESET write does not disturb COUNT; EN=0 freezes it
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);                    // e0
    tick(); tick(); tick(); tick();
    rd("mid_count_e4", 2'd2, 32'd8);
    wr(2'd1, 32'd100);                  // e5
    rd("mid_count_e5", 2'd2, 32'd7);
    tick(); rd("mid_count_e6", 2'd2, 32'd6);
    wr(2'd0, 32'h8);                    // e7, still counting on this edge
    rd("mid_count_e7", 2'd2, 32'd5);
    tick(); tick(); tick();
    rd("frozen_count", 2'd2, 32'd5);
    rd("new_preset", 2'd1, 32'd100);
    chk_irq("frozen_irq", 1'b0);

    // Asynchronous reset mid-count with COUNT=5
    do_reset();
    wr(2'd1, 32'd8);
    wr(2'd0, 32'h9);                    // e0
    tick(); tick(); tick(); tick(); tick();
    rd("pre_abort_count", 2'd2, 32'd5);
    reset = 1'b0;
    rd("abort_count", 2'd2, 32'd0);
    rd("abort_ctrl", 2'd0, 32'd0);
    rd("abort_preset", 2'd1, PR);
    chk_irq("abort_irq", 1'b0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk_irq("post_abort_irq", 1'b0);
    rd("post_abort_count", 2'd2, 32'd0);

    // Randomized bus traffic checked against the model every cycle
    for (int i = 0; i < 3000; i++) begin
      address     = 2'($urandom_range(0, 3));
      writeEnable = ($urandom_range(0, 3) == 0);
      if (address == 2'd1) writeData = 32'($urandom_range(0, 7));
      else if (address == 2'd0) begin
        writeData      = $urandom;
        writeData[0]   = ($urandom_range(0, 3) != 0);
      end else writeData = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        #3;
        reset = 1'b1;
      end
      tick();
    end
    writeEnable = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
